// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Optional feature macro: PIPELINED_ADDER_OVF_EN (adds the signed overflow output).
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  // Number of operand bits handled by each pipeline stage.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Purely combinational ripple-carry adder for one pipeline slice.
// Besides the slice sum and carry out it exposes the carry into the slice MSB,
// which the top level uses to derive signed overflow on the last slice.
// Optional feature macro of the enclosing design: PIPELINED_ADDER_OVF_EN.
module fa_slice
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [WIDTH:0] carry;

  // Bit-serial ripple of the carry from LSB to MSB.
  always_comb begin
    s        = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = carry[WIDTH];
  assign msb_cin = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with valid/ready handshakes on both sides.
// The operands are cut into STAGES slices; slice k is added in stage k using
// the carry registered by stage k-1. Upper operand slices are delayed on the
// way in and finished sum slices are delayed on the way out, so every beat
// leaves with a coherent Sum exactly STAGES cycles after it was accepted.
// A stall (result offered but not taken) freezes every register.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the Ovf output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             Cout
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_check
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] stage_cout;
  logic [STAGES-1:0] stage_msb;
  logic              stall;
  logic              advance;
  logic              unused_msb;

  assign out_valid = valid_q[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign Cout      = carry_q[STAGES-1];

  // MSB carries of the inner slices only matter on the last slice.
  assign unused_msb = ^stage_msb;

  // Valid bits and inter-stage carries move one stage per non-stalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      carry_q <= stage_cout;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] s_slice;
    logic             c_in;
    logic [SLICE-1:0] sum_dly [STAGES-k];

    if (k == 0) begin : g_head
      assign a_slice = A[SLICE-1:0];
      assign b_slice = B[SLICE-1:0];
      assign c_in    = C;
    end else begin : g_skew
      logic [SLICE-1:0] a_dly [k];
      logic [SLICE-1:0] b_dly [k];

      // Delay this operand slice by k cycles so it meets its beat's carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            a_dly[j] <= '0;
            b_dly[j] <= '0;
          end
        end else if (advance) begin
          a_dly[0] <= A[k*SLICE +: SLICE];
          b_dly[0] <= B[k*SLICE +: SLICE];
          for (int j = 1; j < k; j++) begin
            a_dly[j] <= a_dly[j-1];
            b_dly[j] <= b_dly[j-1];
          end
        end
      end

      assign a_slice = a_dly[k-1];
      assign b_slice = b_dly[k-1];
      assign c_in    = carry_q[k-1];
    end

    fa_slice #(
      .WIDTH(SLICE)
    ) u_fa (
      .a      (a_slice),
      .b      (b_slice),
      .cin    (c_in),
      .s      (s_slice),
      .cout   (stage_cout[k]),
      .msb_cin(stage_msb[k])
    );

    // Register the slice sum, then hold it back until the last slice is done.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < STAGES - k; j++) begin
          sum_dly[j] <= '0;
        end
      end else if (advance) begin
        sum_dly[0] <= s_slice;
        for (int j = 1; j < STAGES - k; j++) begin
          sum_dly[j] <= sum_dly[j-1];
        end
      end
    end

    assign Sum[k*SLICE +: SLICE] = sum_dly[STAGES-k-1];
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow is registered together with the last slice and its carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= stage_cout[STAGES-1] ^ stage_msb[STAGES-1];
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder.
// Results are compared against an arithmetic reference (A+B+C on integers)
// kept in a scoreboard queue; stalls, bubbles and resets are exercised.
// Optional feature macro: PIPELINED_ADDER_OVF_EN (also checks Ovf).
module tb_pipelined_adder;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t front;
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  pipelined_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
`ifdef PIPELINED_ADDER_OVF_EN
    .Ovf      (ovf),
`endif
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .C        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (sum),
    .Cout     (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, unsigned for Sum/Cout, signed range for Ovf.
  function automatic exp_t model(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                                 input logic c_v);
    exp_t             r;
    longint unsigned  total;
    longint           stotal;
    longint           max_s;
    longint           min_s;
    total  = longint'(a_v) + longint'(b_v) + longint'(c_v);
    stotal = longint'($signed(a_v)) + longint'($signed(b_v)) + longint'(c_v);
    max_s  = (longint'(1) <<< (WIDTH - 1)) - 1;
    min_s  = -(longint'(1) <<< (WIDTH - 1));
    r.sum  = total[WIDTH-1:0];
    r.cout = total[WIDTH];
    r.ovf  = (stotal > max_s) || (stotal < min_s);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one beat and hold it until the adder takes it (bounded wait).
  task automatic applyStimulus(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                               input logic c_v);
    bit taken = 1'b0;
    a        = a_v;
    b        = b_v;
    c        = c_v;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !taken; n++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    checkOutput("accept", 64'(taken), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: outputs checked against the oldest pending beat every cycle,
  // which also proves the result is held steady during a stall.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("orphan_result", 64'(out_valid), 64'(0));
        end else begin
          front = exp_q[0];
          checkOutput("sum", 64'(sum), 64'(front.sum));
          checkOutput("cout", 64'(cout), 64'(front.cout));
`ifdef PIPELINED_ADDER_OVF_EN
          checkOutput("ovf", 64'(ovf), 64'(front.ovf));
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_sum", 64'(sum), 64'(0));
    checkOutput("rst_cout", 64'(cout), 64'(0));
`ifdef PIPELINED_ADDER_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'(0));
`endif

    // First beat right after reset release; carry crosses slice boundary.
    rst      = 1'b0;
    a        = WIDTH'(15);
    b        = WIDTH'(1);
    c        = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    checkOutput("latency", 64'(n + 1), 64'(STAGES));
    @(posedge clk);
    #1;

    // Wrap-around and signed overflow corners.
    applyStimulus('1, '0, 1'b1);
    applyStimulus('1, WIDTH'(1), 1'b0);
    applyStimulus(MAX_POS, WIDTH'(1), 1'b0);
    applyStimulus(~MAX_POS, ~MAX_POS, 1'b0);
    applyStimulus('1, '1, 1'b1);
    drain();

    // Back-to-back beats emerge on consecutive cycles.
    pop_cyc.delete();
    applyStimulus(WIDTH'(3), WIDTH'(4), 1'b0);
    applyStimulus(WIDTH'(5), WIDTH'(6), 1'b0);
    applyStimulus(WIDTH'(250), WIDTH'(10), 1'b0);
    drain();
    checkOutput("b2b_count", 64'(pop_cyc.size()), 64'(3));
    if (pop_cyc.size() >= 3) begin
      checkOutput("b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'(1));
      checkOutput("b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'(1));
    end

    // Consumer stalls for three cycles while results are pending.
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(WIDTH'(17), WIDTH'(34), 1'b1);
        applyStimulus(WIDTH'(200), WIDTH'(100), 1'b0);
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) begin
          @(negedge clk);
        end
        checkOutput("stall_valid", 64'(out_valid), 64'(1));
        checkOutput("stall_ready0", 64'(in_ready), 64'(0));
        repeat (2) begin
          @(negedge clk);
          checkOutput("stall_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight discards them.
    applyStimulus(WIDTH'(9), WIDTH'(9), 1'b0);
    applyStimulus(WIDTH'(21), WIDTH'(22), 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("midrst_sum", 64'(sum), 64'(0));
    checkOutput("midrst_cout", 64'(cout), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    repeat (3 * STAGES + 4) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checkOutput("midrst_stale", 64'(n), 64'(0));
    @(posedge clk);
    #1;

    // Random traffic with bubbles and back-pressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("idle_out_valid", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 2, pipeline stages; WIDTH SHALL be divisible by STAGES, else elaboration error.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C  in  1  carry-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  A+B+C modulo 2^WIDTH.
- Cout  out  1  carry out of MSB.
- Ovf  out  1  signed overflow, only present with PIPELINED_ADDER_OVF_EN.

Function
REQ-004 SHALL split operands into STAGES slices of SLICE=WIDTH/STAGES bits; stage k adds slice k (slice 0 = LSBs) using the carry registered by stage k-1 (stage 0 uses C).
REQ-005 SHALL register each stage's slice sum, slice carry and a valid bit; operand slices k>0 SHALL be skewed by k register stages, completed sum slices deskewed, so Sum is coherent per beat.
REQ-006 SHALL have latency exactly STAGES cycles from accepted beat (in_valid && in_ready at edge) to out_valid, absent stalls.
REQ-007 SHALL sustain one beat per cycle when out_ready held high.
REQ-008 Stall: stall = out_valid && !out_ready; when stall, all pipeline registers SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-009 Sum/Cout/Ovf SHALL stay stable while out_valid && !out_ready.
REQ-010 Bubbles (in_valid=0 on accept) SHALL propagate as invalid stages; data registers of invalid stages are don't-care, but out_valid SHALL be 0 for them.
REQ-011 in_ready SHALL depend on out_valid/out_ready only, never on in_valid (no combinational loop).
REQ-012 Wrap-around: all-ones + 1 SHALL give Sum=0, Cout=1; no saturation.
REQ-013 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder, latency 1.

Reset
REQ-014 rst assertion SHALL immediately clear all valid bits; out_valid=0, in_ready=1, Sum=0, Cout=0, Ovf=0.
REQ-015 Reset mid-operation SHALL discard every in-flight beat; no stale result after deassertion.
REQ-016 First beat SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-017 Macro PIPELINED_ADDER_OVF_EN: when defined, Ovf port and logic exist; Ovf = carry into MSB XOR Cout, pipelined aligned with Sum.
REQ-018 Without PIPELINED_ADDER_OVF_EN, Ovf port and its registers SHALL be absent; all other behaviour identical.

Structure
REQ-019 Shared package pipelined_adder_pkg SHALL hold default WIDTH/STAGES constants and a function computing SLICE.
REQ-020 One sub-module fa_slice SHALL implement a combinational SLICE-bit ripple-carry adder (a, b, cin -> s, cout, MSB carry-in), instantiated once per stage.
REQ-021 All sequential logic SHALL reside in pipelined_adder; fa_slice SHALL contain no registers.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-022 A=8'h0F, B=8'h01, C=0, out_ready=1 -> after 2 cycles out_valid=1, Sum=8'h10, Cout=0 (carry crosses slices).
REQ-023 A=8'hFF, B=8'h00, C=1 -> Sum=8'h00, Cout=1; with OVF_EN, A=8'h7F, B=8'h01, C=0 -> Sum=8'h80, Ovf=1.
REQ-024 Back-to-back beats 3+4, 5+6, 250+10 with out_ready=1 -> consecutive results 7, 11, 4 (Cout=1) on three consecutive cycles.
REQ-025 out_ready=0 for 3 cycles while results pending -> in_ready=0, Sum held; release -> results in order, none lost or duplicated.
REQ-026 Assert rst with two beats in flight -> out_valid=0 immediately, no result emitted after release; exhaustive 8-bit random vs A+B+C model, also STAGES=1, 4, 8.
